xadc_axi_lite_regs: RTL
=======================

Name: xadc_axi_lite_regs

Overview:
- AXI4-Lite slave (responder) register block for the XADC peripheral; the target that the block-design AXI4-Lite master BFM writes and reads.
- Four 32-bit read/write control registers at byte offsets 0x0, 0x4, 0x8 and 0xC, with byte strobes.
- Register contents drive the downstream XADC control logic through a flat output bus, with one write-strobe pulse per register.
- Single outstanding write and single outstanding read; the write and read channels operate independently.

Parameters:
- ADDR_W, 6, address width in bits; 64-byte window, word index = addr[ADDR_W-1:2].
- DATA_W, 32, data width in bits; fixed at 32.
- RST_VAL, 128'h0, reset value of reg0..reg3, packed {reg3,reg2,reg1,reg0}.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write-address valid.
- S_AXI_AWREADY  out  1  write-address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write-data valid.
- S_AXI_WREADY  out  1  write-data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write-response valid.
- S_AXI_BREADY  in  1  write-response ready.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read-address valid.
- S_AXI_ARREADY  out  1  read-address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read-data valid.
- S_AXI_RREADY  in  1  read-data ready.
- regs_o  out  128  {reg3,reg2,reg1,reg0}.
- wr_pulse_o  out  4  one-cycle pulse; bit i high for the cycle after reg i is written.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - reg0..reg3 load RST_VAL.
  - AWREADY, WREADY, ARREADY, BVALID and RVALID go low; BRESP, RRESP, RDATA and wr_pulse_o go to 0.
  - aw_held and w_held clear; any in-flight transaction is dropped with no response.
  - The *READY outputs are registered flags. They rise on the first edge after reset release, when the block is idle.
- Write path uses the states W_IDLE and W_RESP, plus aw_held and w_held flags with their captured address and data/strobe.
  - In W_IDLE:
    - AWREADY = !aw_held.
    - WREADY = !w_held.
    - An AW handshake captures the address and sets aw_held.
    - A W handshake captures data and strobe and sets w_held.
    - AW and W may arrive in either order or in the same cycle.
  - Commit occurs at the edge where both the address and the data are available (held or handshaking that edge):
    - the addressed register updates per byte, byte k written only when WSTRB[k]=1;
    - BVALID=1 and BRESP=00;
    - the state moves to W_RESP;
    - both held flags clear;
    - the wr_pulse_o bit for the addressed register is high for the next cycle only.
  - In W_RESP: AWREADY=0 and WREADY=0. BVALID holds until BREADY=1, then returns to W_IDLE at that edge.
  - WSTRB=0: the write completes with OKAY, no register changes, and wr_pulse_o still pulses.
- Read path uses the states R_IDLE and R_DATA.
  - In R_IDLE: ARREADY=1. An AR handshake latches RDATA from the addressed register, sets RVALID=1 and RRESP=00, and moves to R_DATA.
  - In R_DATA: ARREADY=0. RDATA and RRESP are stable until RREADY=1, then return to R_IDLE.
  - Read latency: RVALID rises on the edge after the AR handshake.
- Simultaneous events:
  - A read and a write committing to the same register on the same edge: the read returns the pre-write value.
  - Read and write paths never stall each other.
- Address decoding: addr[1:0] is ignored. Word index 0..3 selects reg0..reg3. Word index 4..15 is unmapped.
  - Unmapped writes are discarded.
  - Unmapped reads return 0.
  - Both respond OKAY (see Optional Feature).

Optional Feature:
- Macro: XADC_AXI_SLVERR_EN.
- Defined: unmapped accesses return SLVERR (2'b10) on BRESP or RRESP. Unmapped writes are discarded with no wr_pulse_o. Unmapped reads return RDATA=0.
- Undefined: unmapped accesses return OKAY, and writes are silently dropped.

Test Plan:
- Sequential write then read at 0x0, 0x4, 0x8, 0xC with data 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 -> each BRESP=00 and RRESP=00, readback equal to the written data, wr_pulse_o=0001, 0010, 0100, 1000 respectively.
- W presented 3 cycles before AW (data 0x12345678 to 0x4), BREADY held low 5 cycles -> WREADY handshake first; commit only after the AW handshake; BVALID stays high for 5 cycles; reg1=0x12345678.
- reg2=0xdead0011, then write 0xFFFFFFFF with WSTRB=0101 -> reg2=0xdeFF00FF; readback matches.
- Read of 0x8 and write of 0x0000AAAA to 0x8 committing on the same edge, reg2 previously 0xdead0011 -> RDATA=0xdead0011; subsequent read returns 0x0000AAAA.
- Write to 0x20, then read of 0x20 -> without the macro: OKAY, RDATA=0, regs unchanged; with XADC_AXI_SLVERR_EN: BRESP=10, RRESP=10, no wr_pulse_o.
- ARESET asserted while BVALID=1 and RVALID=1 -> both drop immediately (asynchronously); regs_o=RST_VAL; the first transaction after release completes normally.

Source files
------------

// File: rtl/xadc_axi_lite_regs.sv
// AXI4-Lite slave with four 32-bit byte-strobed control registers driving the XADC control logic.
// Define XADC_AXI_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module xadc_axi_lite_regs #(
    parameter int                   ADDR_W  = 6,
    parameter int                   DATA_W  = 32,
    parameter logic [4*DATA_W-1:0]  RST_VAL = 128'h0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [4*DATA_W-1:0]   regs_o,
    output logic [3:0]            wr_pulse_o
);
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
`ifdef XADC_AXI_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    logic [3:0][DATA_W-1:0] regs_q, regs_d;
    logic [0:0]             w_state_q, w_state_d, r_state_q, r_state_d;
    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W/8-1:0]    wstrb_q, wstrb_d;
    logic                   awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [3:0]             wr_pulse_q, wr_pulse_d;

    logic                   aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [DATA_W/8-1:0]    wr_strb;
    logic [ADDR_W-3:0]      wr_word, rd_word;
    logic                   wr_mapped, rd_mapped;
    logic                   unused_ok;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;

    // A beat handshaking this edge is used directly so commit needs no extra cycle.
    assign wr_addr   = aw_held_q ? awaddr_q : S_AXI_AWADDR;
    assign wr_data   = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb   = w_held_q  ? wstrb_q  : S_AXI_WSTRB;
    assign wr_word   = wr_addr[ADDR_W-1:2];
    assign rd_word   = S_AXI_ARADDR[ADDR_W-1:2];
    assign wr_mapped = (wr_word[ADDR_W-3:2] == '0);
    assign rd_mapped = (rd_word[ADDR_W-3:2] == '0);
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        if (w_state_q == W_IDLE) begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end
            if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                if (wr_mapped) begin
                    for (int k = 0; k < DATA_W/8; k++) begin
                        if (wr_strb[k]) regs_d[wr_word[1:0]][8*k +: 8] = wr_data[8*k +: 8];
                    end
                    wr_pulse_d = 4'b0001 << wr_word[1:0];
                end
                bvalid_d  = 1'b1;
                bresp_d   = wr_mapped ? 2'b00 : RESP_UNMAPPED;
                w_state_d = W_RESP;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                awready_d = 1'b0;
                wready_d  = 1'b0;
            end else begin
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
            end
        end else if (S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            w_state_d = W_IDLE;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
    end

    // Reads sample regs_q, so a same-edge write is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (r_state_q == R_IDLE) begin
            arready_d = 1'b1;
            if (ar_hs) begin
                rdata_d   = rd_mapped ? regs_q[rd_word[1:0]] : '0;
                rresp_d   = rd_mapped ? 2'b00 : RESP_UNMAPPED;
                rvalid_d  = 1'b1;
                arready_d = 1'b0;
                r_state_d = R_DATA;
            end
        end else if (S_AXI_RREADY) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q     <= RST_VAL;
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign regs_o        = regs_q;
    assign wr_pulse_o    = wr_pulse_q;
endmodule
